// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: MIPS ID stage with registered ID/EX control bundle.
// Optional unknown-opcode trap: define DECODE_ILLEGAL_TRAP_EN.
module decode_ctrl_stage #(
   parameter int XLEN    = 32,
   parameter int ALUOP_W = 3,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               if_valid,
   input  logic [XLEN-1:0]    if_instr,
   output logic               id_ready,
   input  logic               ex_ready,
   input  logic               ex_flush,
   input  logic               resume,
   output logic               ex_valid,
   output logic [ALUOP_W-1:0] ex_aluop,
   output logic               ex_regdest,
   output logic               ex_regwrite,
   output logic               ex_alusrc,
   output logic               ex_memread,
   output logic               ex_memwrite,
   output logic               ex_memtoreg,
   output logic               ex_branch,
   output logic               ex_invertzero,
   output logic               ex_jump,
   output logic [4:0]         ex_rs,
   output logic [4:0]         ex_rt,
   output logic [4:0]         ex_rd,
   output logic [XLEN-1:0]    ex_imm,
   output logic [1:0]         ex_class,
   output logic               halted,
   output logic               illegal,
   output logic [CNT_W-1:0]   bubble_cnt
);

   typedef enum logic {RUN, HALT} state_t;

   typedef struct packed {
      logic               valid;
      logic [ALUOP_W-1:0] aluop;
      logic               regdest;
      logic               regwrite;
      logic               alusrc;
      logic               memread;
      logic               memwrite;
      logic               memtoreg;
      logic               branch;
      logic               invertzero;
      logic               jump;
      logic [4:0]         rs;
      logic [4:0]         rt;
      logic [4:0]         rd;
      logic [XLEN-1:0]    imm;
      logic [1:0]         cls;
   } id_ex_t;

   state_t state, state_n;
   id_ex_t q, dec;

   logic [5:0] op, funct;
   logic is_nop, is_sys, is_r, is_lw, is_sw;
   logic is_beq, is_bne, is_addi, is_andi;
   logic is_ori, is_slti, is_j;
   logic dec_ok, reads_rt, load_use;
   logic take, bub_inc, ill_set;
   logic [XLEN-1:0] imm_s, imm_z, imm_j;

   assign op      = if_instr[31:26];
   assign funct   = if_instr[5:0];
   assign is_nop  = (if_instr == '0);
   assign is_sys  = (op == 6'h00) && (funct == 6'h0c);
   assign is_r    = (op == 6'h00) && !is_nop && !is_sys;
   assign is_lw   = (op == 6'h23);
   assign is_sw   = (op == 6'h2b);
   assign is_beq  = (op == 6'h04);
   assign is_bne  = (op == 6'h05);
   assign is_addi = (op == 6'h08);
   assign is_andi = (op == 6'h0c);
   assign is_ori  = (op == 6'h0d);
   assign is_slti = (op == 6'h0a);
   assign is_j    = (op == 6'h02);

   assign imm_s = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};
   assign imm_z = {{(XLEN-16){1'b0}}, if_instr[15:0]};
   assign imm_j = {{(XLEN-26){1'b0}}, if_instr[25:0]};

   assign reads_rt = (op == 6'h00) | is_sw | is_beq | is_bne;

   // load in EX whose rt feeds the word now in ID
   assign load_use = if_valid & q.valid & q.memread
                   & (q.rt != 5'd0)
                   & ((q.rt == if_instr[25:21])
                   | ((q.rt == if_instr[20:16]) & reads_rt));

   // instruction decode into the ID/EX bundle
   always_comb begin
      dec    = '0;
      dec_ok = 1'b1;
      dec.rs  = if_instr[25:21];
      dec.rt  = if_instr[20:16];
      dec.rd  = if_instr[15:11];
      dec.imm = imm_s;
      unique case (1'b1)
         is_nop, is_sys: dec_ok = 1'b0;
         is_r: begin
            dec.aluop    = ALUOP_W'(3'b010);
            dec.regdest  = 1'b1;
            dec.regwrite = 1'b1;
            dec.cls      = 2'b01;
         end
         is_lw: begin
            dec.regwrite = 1'b1;
            dec.alusrc   = 1'b1;
            dec.memread  = 1'b1;
            dec.memtoreg = 1'b1;
            dec.cls      = 2'b10;
         end
         is_sw: begin
            dec.alusrc   = 1'b1;
            dec.memwrite = 1'b1;
            dec.cls      = 2'b10;
         end
         is_beq, is_bne: begin
            dec.aluop      = ALUOP_W'(3'b001);
            dec.branch     = 1'b1;
            dec.invertzero = is_bne;
            dec.cls        = 2'b10;
         end
         is_addi, is_slti: begin
            dec.aluop    = is_slti ? ALUOP_W'(3'b111)
                                   : ALUOP_W'(3'b000);
            dec.regwrite = 1'b1;
            dec.alusrc   = 1'b1;
            dec.cls      = 2'b10;
         end
         is_andi, is_ori: begin
            dec.aluop    = is_ori ? ALUOP_W'(3'b100)
                                  : ALUOP_W'(3'b011);
            dec.regwrite = 1'b1;
            dec.alusrc   = 1'b1;
            dec.imm      = imm_z;
            dec.cls      = 2'b10;
         end
         is_j: begin
            dec.jump = 1'b1;
            dec.imm  = imm_j;
            dec.cls  = 2'b11;
         end
         default: dec_ok = 1'b0;
      endcase
      dec.valid = dec_ok;
   end

   // handshake, hazard and RUN/HALT next-state
   always_comb begin
      state_n  = state;
      id_ready = 1'b0;
      take     = 1'b0;
      bub_inc  = 1'b0;
      ill_set  = 1'b0;
      if (state == RUN) begin
         id_ready = ex_ready & (ex_flush | ~load_use);
         if (ex_ready & ~ex_flush) begin
            if (load_use) begin
               bub_inc = 1'b1;
            end else if (if_valid) begin
               take = dec_ok;
               if (is_sys) state_n = HALT;
`ifdef DECODE_ILLEGAL_TRAP_EN
               if (!dec_ok && !is_nop && !is_sys) begin
                  ill_set = 1'b1;
                  state_n = HALT;
               end
`endif
            end
         end
      end else if (resume) begin
         state_n = RUN;
      end
   end

   // state, ID/EX register and bubble counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RUN;
         q          <= '0;
         bubble_cnt <= '0;
      end else begin
         state <= state_n;
         if (ex_ready) q <= take ? dec : '0;
         if (bub_inc && bubble_cnt != '1)
            bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end

`ifdef DECODE_ILLEGAL_TRAP_EN
   logic ill_q;
   // sticky until reset; resume does not clear it
   always_ff @(posedge clk) begin
      if (rst) ill_q <= 1'b0;
      else if (ill_set) ill_q <= 1'b1;
   end
   assign illegal = ill_q;
`else
   logic unused_ill;
   assign unused_ill = ill_set;
   assign illegal    = 1'b0;
`endif

   assign halted        = (state == HALT);
   assign ex_valid      = q.valid;
   assign ex_aluop      = q.aluop;
   assign ex_regdest    = q.regdest;
   assign ex_regwrite   = q.regwrite;
   assign ex_alusrc     = q.alusrc;
   assign ex_memread    = q.memread;
   assign ex_memwrite   = q.memwrite;
   assign ex_memtoreg   = q.memtoreg;
   assign ex_branch     = q.branch;
   assign ex_invertzero = q.invertzero;
   assign ex_jump       = q.jump;
   assign ex_rs         = q.rs;
   assign ex_rt         = q.rt;
   assign ex_rd         = q.rd;
   assign ex_imm        = q.imm;
   assign ex_class      = q.cls;

endmodule
